mem_access_initiator: RTL

MEM_ACCESS_INITIATOR -- requirements
Module: mem_access_initiator

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_lat_counter.sv | 45 ++++
 rtl/mem_access_initiator.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory access initiator:
//   - state_t  : request FSM states (IDLE / ISSUE / WAIT / RESP)
//   - WORD_AW  : width of the memory-side word address (byte address >> 2)
//   - CNT_W    : width of the read-latency down-counter (RD_LAT-1 fits in it)
//   - byte_to_word : helper that drops the byte offset of a 32-bit address
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int unsigned WORD_AW = 30;
  localparam int unsigned CNT_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic [WORD_AW-1:0] byte_to_word(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// -----------------------------------------------------------------------------
// mem_lat_counter
// Read-latency down-counter used while a load waits for memory data.
// Ports:
//   clk        : clock, all state on posedge
//   rst        : asynchronous active-low reset (count 0, zero flag set)
//   i_load     : load i_load_val (has priority over decrement)
//   i_load_val : value to load
//   i_dec      : decrement by one; ignored once the count is already zero
//   o_zero     : registered flag, 1 when the count is zero
// -----------------------------------------------------------------------------
module mem_lat_counter
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_zero;

  // Count register with a zero flag computed one step ahead so it is a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_zero <= 1'b1;
    end else if (i_load) begin
      r_cnt  <= i_load_val;
      r_zero <= (i_load_val == {CNT_W{1'b0}});
    end else if (i_dec && !r_zero) begin
      r_cnt  <= r_cnt - CNT_W'(1);
      r_zero <= (r_cnt == CNT_W'(1));
    end else begin
      r_cnt  <= r_cnt;
      r_zero <= r_zero;
    end
  end

  assign o_zero = r_zero;

endmodule

// File: rtl/mem_access_initiator.sv
// -----------------------------------------------------------------------------
// mem_access_initiator
// Turns one CPU load/store request at a time into a single-cycle memory
// strobe (E with mem_wren or mem_rren), waits RD_LAT cycles for load data,
// and returns a response held until rsp_ready. jisr aborts the transaction.
//
// Parameter:
//   RD_LAT : read-data latency in clk cycles from the issue cycle (1..4)
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   req_valid/req_ready          : request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata  : store flag, byte address, store data
//   rsp_valid/rsp_ready          : response handshake
//   rsp_rdata, rsp_err           : load data (0 for stores), error flag
//   jisr                         : flush / jump-to-ISR
//   addr_in, data_in             : memory word address and write data (held)
//   mem_wren, mem_rren, E        : memory strobes, high in the ISSUE cycle only
//   out                          : memory read data
// Build option:
//   MEM_MISALIGN_CHECK_EN : when defined, a request with req_addr[1:0] != 0
//   never reaches memory and is answered directly with rsp_err=1, rdata=0.
//   When undefined, the byte offset is ignored and rsp_err is always 0.
// -----------------------------------------------------------------------------
module mem_access_initiator
  import mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  input  logic               jisr,
  output logic [WORD_AW-1:0] addr_in,
  output logic [31:0]        data_in,
  output logic               mem_wren,
  output logic               mem_rren,
  output logic               E,
  input  logic [31:0]        out
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

  state_t             r_state;
  logic               r_we;
  logic [WORD_AW-1:0] r_addr;
  logic [31:0]        r_wdata;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_err;
  logic               r_e;
  logic               r_wren;
  logic               r_rren;

  logic               w_accept;
  logic               w_misalign;
  logic               w_cnt_load;
  logic               w_cnt_dec;
  logic               w_cnt_zero;

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign = (req_addr[1:0] != 2'b00);
`else
  logic w_unused_addr_lsb;
  assign w_misalign        = 1'b0;
  assign w_unused_addr_lsb = ^req_addr[1:0];
`endif

  // jisr in IDLE holds off acceptance for that cycle.
  assign w_accept   = req_valid & r_req_ready & ~jisr;
  assign w_cnt_load = (r_state == ISSUE);
  assign w_cnt_dec  = (r_state == WAIT);

  mem_lat_counter u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (LAT_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Request FSM; every output is a flop set on the edge that enters its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_addr      <= {WORD_AW{1'b0}};
      r_wdata     <= 32'h0000_0000;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
      r_e         <= 1'b0;
      r_wren      <= 1'b0;
      r_rren      <= 1'b0;
    end else begin
      // Strobes are single-cycle; only the accepting edge raises them.
      r_e    <= 1'b0;
      r_wren <= 1'b0;
      r_rren <= 1'b0;
      case (r_state)
        IDLE: begin
          r_rsp_valid <= 1'b0;
          if (w_accept && w_misalign) begin
            // Misaligned request bypasses memory entirely.
            r_state     <= RESP;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b1;
          end else if (w_accept) begin
            r_state     <= ISSUE;
            r_req_ready <= 1'b0;
            r_we        <= req_we;
            r_addr      <= byte_to_word(req_addr);
            r_wdata     <= req_wdata;
            r_e         <= 1'b1;
            r_wren      <= req_we;
            r_rren      <= ~req_we;
          end else begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
          end
        end
        ISSUE: begin
          // The strobes of this cycle have already gone out; an abort
          // here only suppresses the response.
          if (jisr) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
          end else if (r_we) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (jisr) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
          end else if (w_cnt_zero) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= out;
            r_rsp_err   <= 1'b0;
          end else begin
            r_state <= WAIT;
          end
        end
        RESP: begin
          if (jisr || rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end else begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign addr_in   = r_addr;
  assign data_in   = r_wdata;
  assign E         = r_e;
  assign mem_wren  = r_wren;
  assign mem_rren  = r_rren;

endmodule
